// File: rtl/isa_pkg.sv
// RV32 subset constants, microcode entry addresses and decode-stage types
// shared by the decode/issue stage and the micro-sequencer ROM.
package isa_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 values
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_JALR = 3'b000;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Microcode entry addresses (also the micro-sequencer ROM indices)
    typedef logic [4:0] uaddr_t;
    localparam uaddr_t UA_LOAD  = 5'd0;
    localparam uaddr_t UA_STORE = 5'd2;
    localparam uaddr_t UA_ADD   = 5'd4;
    localparam uaddr_t UA_AND   = 5'd5;
    localparam uaddr_t UA_XOR   = 5'd6;
    localparam uaddr_t UA_OR    = 5'd7;
    localparam uaddr_t UA_ADDI  = 5'd8;
    localparam uaddr_t UA_ANDI  = 5'd9;
    localparam uaddr_t UA_XORI  = 5'd10;
    localparam uaddr_t UA_ORI   = 5'd11;
    localparam uaddr_t UA_LUI   = 5'd12;
    localparam uaddr_t UA_AUIPC = 5'd13;
    localparam uaddr_t UA_JAL   = 5'd14;
    localparam uaddr_t UA_JALR  = 5'd16;
    localparam uaddr_t UA_BEQ   = 5'd19;
    localparam uaddr_t UA_BLTU  = 5'd21;
    localparam uaddr_t UA_SUB   = 5'd24;
    localparam uaddr_t UA_SHIFT = 5'd27;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    typedef enum logic [1:0] {IDLE, BUSY, TRAP} decode_state_e;

endpackage

// File: rtl/inst_field_decoder.sv
// Combinational instruction classifier: microcode entry, immediate format,
// operand swap / branch negate qualifiers and illegal-encoding detection.
module inst_field_decoder
    import isa_pkg::*;
(
    input  logic [31:0] instr,
    output uaddr_t      uaddr,
    output imm_fmt_e    imm_fmt,
    output logic        swap,
    output logic        negate,
    output logic        is_branch,
    output logic        illegal
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];

    // Classify the instruction word; anything not matched stays illegal
    always_comb begin
        uaddr     = UA_LOAD;
        imm_fmt   = IMM_NONE;
        swap      = 1'b0;
        negate    = 1'b0;
        is_branch = 1'b0;
        illegal   = 1'b1;
        case (opc)
            OPC_LOAD: if (f3 == F3_LW) begin
                uaddr = UA_LOAD; imm_fmt = IMM_I; illegal = 1'b0;
            end
            OPC_STORE: if (f3 == F3_SW) begin
                uaddr = UA_STORE; imm_fmt = IMM_S; illegal = 1'b0;
            end
            OPC_OP: begin
                if (f7 == F7_BASE) begin
                    illegal = 1'b0;
                    case (f3)
                        F3_ADD:  uaddr = UA_ADD;
                        F3_AND:  uaddr = UA_AND;
                        F3_XOR:  uaddr = UA_XOR;
                        F3_OR:   uaddr = UA_OR;
                        default: illegal = 1'b1;
                    endcase
                end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                    uaddr = UA_SUB; swap = 1'b1; illegal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                imm_fmt = IMM_I;
                illegal = 1'b0;
                case (f3)
                    F3_ADD:  uaddr = UA_ADDI;
                    F3_AND:  uaddr = UA_ANDI;
                    F3_XOR:  uaddr = UA_XORI;
                    F3_OR:   uaddr = UA_ORI;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LUI:   begin uaddr = UA_LUI;   imm_fmt = IMM_U; illegal = 1'b0; end
            OPC_AUIPC: begin uaddr = UA_AUIPC; imm_fmt = IMM_U; illegal = 1'b0; end
            OPC_JAL:   begin uaddr = UA_JAL;   imm_fmt = IMM_J; illegal = 1'b0; end
            OPC_JALR: if (f3 == F3_JALR) begin
                uaddr = UA_JALR; imm_fmt = IMM_I; illegal = 1'b0;
            end
            OPC_BRANCH: begin
                imm_fmt   = IMM_B;
                is_branch = 1'b1;
                illegal   = 1'b0;
                case (f3)
                    F3_BEQ:  begin uaddr = UA_BEQ;  negate = 1'b1; end
                    F3_BNE:  uaddr = UA_BEQ;
                    F3_BLTU: begin uaddr = UA_BLTU; swap = 1'b1; end
                    F3_BGEU: begin uaddr = UA_BLTU; swap = 1'b1; negate = 1'b1; end
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        // Unrecognised forms must not leak qualifiers into the stage
        if (illegal) begin
            uaddr     = UA_LOAD;
            imm_fmt   = IMM_NONE;
            swap      = 1'b0;
            negate    = 1'b0;
            is_branch = 1'b0;
        end
    end

endmodule

// File: rtl/inst_decode_issue.sv
// Decode/issue stage: registers decoded fields of an accepted instruction and
// holds them for the micro-sequencer until it signals completion.
module inst_decode_issue
    import isa_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid_inst,
    input  logic [31:0]      if_instr,
    input  logic [XLEN-1:0]  if_pc,
    output logic             id_ready,
    input  logic             rf_valid_inst,
    output logic             id_rf_valid_inst,
    output logic [4:0]       decode_addr,
    output logic [4:0]       rs1_idx,
    output logic [4:0]       rs2_idx,
    output logic [4:0]       rd_idx,
    output logic [XLEN-1:0]  imm,
    output logic [XLEN-1:0]  id_pc,
    output logic             swap_operands,
    output logic             is_branch,
    output logic             br_negate,
    output logic             illegal_inst,
    output logic [CNT_W-1:0] retired_cnt
);

    decode_state_e state_q, state_d;
    uaddr_t        dec_uaddr;
    imm_fmt_e      dec_fmt;
    logic          dec_swap, dec_negate, dec_branch, dec_illegal;
    logic          accept, retire;
    logic [31:0]   imm32;
    logic [4:0]    rs1_d, rs2_d, rd_d;

    inst_field_decoder u_fields (
        .instr     (if_instr),
        .uaddr     (dec_uaddr),
        .imm_fmt   (dec_fmt),
        .swap      (dec_swap),
        .negate    (dec_negate),
        .is_branch (dec_branch),
        .illegal   (dec_illegal)
    );

    // Assemble the 32-bit immediate for the decoded format
    always_comb begin
        imm32 = '0;
        case (dec_fmt)
            IMM_I: imm32 = {{20{if_instr[31]}}, if_instr[31:20]};
            IMM_S: imm32 = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
            IMM_B: imm32 = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                            if_instr[30:25], if_instr[11:8], 1'b0};
            IMM_U: imm32 = {if_instr[31:12], 12'b0};
            IMM_J: imm32 = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                            if_instr[20], if_instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Register index selection: swap, and zero fields the format lacks
    always_comb begin
        rs1_d = dec_swap ? if_instr[24:20] : if_instr[19:15];
        rs2_d = '0;
        if (dec_swap)
            rs2_d = if_instr[19:15];
        else if (dec_fmt inside {IMM_NONE, IMM_S, IMM_B})
            rs2_d = if_instr[24:20];
        rd_d = (dec_fmt inside {IMM_S, IMM_B}) ? 5'd0 : if_instr[11:7];
    end

    // Ready / accept / retire and next-state
    always_comb begin
        state_d  = state_q;
        id_ready = 1'b0;
        retire   = 1'b0;
        case (state_q)
            IDLE: id_ready = 1'b1;
            BUSY: begin
                id_ready = rf_valid_inst;
                retire   = rf_valid_inst;
            end
            default: id_ready = 1'b0;
        endcase
        accept = if_valid_inst & id_ready;
        if (accept)
            state_d = dec_illegal ? TRAP : BUSY;
        else if (retire)
            state_d = IDLE;
    end

    // State, held instruction fields, sticky illegal flag and retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            decode_addr   <= '0;
            rs1_idx       <= '0;
            rs2_idx       <= '0;
            rd_idx        <= '0;
            imm           <= '0;
            id_pc         <= '0;
            swap_operands <= 1'b0;
            is_branch     <= 1'b0;
            br_negate     <= 1'b0;
            illegal_inst  <= 1'b0;
            retired_cnt   <= '0;
        end else begin
            state_q <= state_d;
            if (retire)
                retired_cnt <= retired_cnt + CNT_W'(1);
            if (accept) begin
                decode_addr   <= dec_uaddr;
                rs1_idx       <= rs1_d;
                rs2_idx       <= rs2_d;
                rd_idx        <= rd_d;
                imm           <= XLEN'($signed(imm32));
                id_pc         <= if_pc;
                swap_operands <= dec_swap;
                is_branch     <= dec_branch;
                br_negate     <= dec_negate;
                if (dec_illegal)
                    illegal_inst <= 1'b1;
            end
        end
    end

    assign id_rf_valid_inst = (state_q == BUSY);

endmodule

// File: doc/inst_decode_issue.md
Name: inst_decode_issue

Overview:
- Decode/issue stage directly upstream of the micro-sequencer.
- Accepts one 32-bit RV32 instruction from fetch and decodes it into a 5-bit microcode entry address, register indices, an immediate and branch qualifiers.
- Holds these stable, with id_rf_valid_inst asserted, until the sequencer reports completion on rf_valid_inst.
- Owns the operand swap required by the SUB/BLTU/BGEU micro-sequences, flags illegal encodings, and counts retired instructions.

Parameters:
- XLEN, 32, data/PC/immediate width.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_valid_inst  in  1  fetch presents a valid instruction
- if_instr  in  32  instruction word
- if_pc  in  XLEN  PC of if_instr
- id_ready  out  1  stage can accept this cycle
- rf_valid_inst  in  1  sequencer finished the current instruction
- id_rf_valid_inst  out  1  decoded instruction valid, sequencer owns control
- decode_addr  out  5  microcode entry address
- rs1_idx  out  5  first source index, after swap
- rs2_idx  out  5  second source index, after swap
- rd_idx  out  5  destination index, 0 for S/B types
- imm  out  XLEN  sign-extended immediate
- id_pc  out  XLEN  PC of the held instruction
- swap_operands  out  1  rs1/rs2 were exchanged
- is_branch  out  1  held instruction is a B-type
- br_negate  out  1  invert the branch condition (BEQ, BGEU)
- illegal_inst  out  1  sticky illegal-encoding flag
- retired_cnt  out  CNT_W  instructions completed

Behaviour:
- **Reset** (synchronous, rst high at a clk edge):
  - state = IDLE.
  - Every output is 0, except id_ready = 1.
  - retired_cnt = 0 and illegal_inst = 0.
  - Reset asserted mid-BUSY discards the held instruction; no retire count.
- **States:** IDLE, BUSY, TRAP.
- **Ready and accept:**
  - id_ready = (state==IDLE) | (state==BUSY & rf_valid_inst); id_ready is 0 in TRAP.
  - Accept = if_valid_inst & id_ready.
  - On accept, all outputs are registered from if_instr/if_pc.
  - id_rf_valid_inst rises the cycle after accept (latency 1).
- **Transitions:**
  - IDLE → BUSY on accept of a legal encoding.
  - IDLE → TRAP on accept of an illegal encoding: illegal_inst set, id_rf_valid_inst stays 0.
  - BUSY with rf_valid_inst: retired_cnt += 1 (wraps at 2^CNT_W).
    - With a simultaneous legal accept: stay BUSY with the new fields; back-to-back issue with no bubble.
    - Simultaneous illegal accept: → TRAP.
    - Otherwise → IDLE with id_rf_valid_inst = 0.
  - BUSY without rf_valid_inst: all outputs are held and if_valid_inst is ignored.
  - TRAP is exited only by rst.
- **decode_addr mapping** (opcode / funct3 / funct7):
  - LW 0000011/010 → 0; SW 0100011/010 → 2.
  - 0110011 with funct7 0000000: ADD/000 → 4, AND/111 → 5, XOR/100 → 6, OR/110 → 7.
  - SUB 0110011/000/0100000 → 24 with swap.
  - 0010011: ADDI/000 → 8, ANDI/111 → 9, XORI/100 → 10, ORI/110 → 11.
  - LUI 0110111 → 12; AUIPC 0010111 → 13; JAL 1101111 → 14; JALR 1100111/000 → 16.
  - 1100011: BEQ/000 → 19 with negate; BNE/001 → 19; BLTU/110 → 21 with swap; BGEU/111 → 21 with swap and negate.
  - Every other encoding is illegal, including instr[1:0] != 11.
- **Immediates:** I, S, B, U and J formats per RV32I, sign-extended from instr[31]. R-type imm = 0.
- **Swap:** when swap_operands = 1, rs1_idx = instr[24:20] and rs2_idx = instr[19:15].
- **Zeroed fields:** rd_idx = 0 for S/B types; rs2_idx = 0 for I/U/J types unless swapped.
- is_branch and br_negate are 0 for all non-branch instructions.

Decomposition:
- Shared package isa_pkg:
  - Opcode constants.
  - funct3/funct7 constants.
  - uaddr_t (5-bit) and the microcode entry constants UA_LOAD = 0 … UA_SHIFT = 27, which micro_control's ROM indices also use.
  - imm_fmt_e enum {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J}.
  - decode_state_e {IDLE, BUSY, TRAP}.
- One combinational sub-module, inst_field_decoder: instr → {uaddr, imm_fmt, swap, negate, is_branch, illegal}.
- Immediate assembly and the state machine stay in the top module.

Test Plan:
- **Reset:** hold rst 3 cycles with if_valid_inst = 1 → id_ready = 1, id_rf_valid_inst = 0, retired_cnt = 0, illegal_inst = 0; nothing is accepted.
- **LW x5,8(x1):** drive 0x0080A283 → next cycle decode_addr = 0, rs1_idx = 1, rd_idx = 5, imm = 8, id_ready = 0. Hold 2 cycles, pulse rf_valid_inst → IDLE, retired_cnt = 1.
- **SUB x3,x1,x2 (0x402081B3):** → decode_addr = 24, swap_operands = 1, rs1_idx = 2, rs2_idx = 1, rd_idx = 3.
- **BNE x1,x2,+8 (0x00209463):** → decode_addr = 19, is_branch = 1, br_negate = 0, imm = 8, rd_idx = 0. Same word with funct3 = 111 (0x0020F463) → decode_addr = 21, swap_operands = 1, br_negate = 1.
- **Back-to-back:** ADD 0x002081B3 held; rf_valid_inst pulsed together with XOR 0x0020C1B3 valid → next cycle decode_addr = 6 with id_rf_valid_inst continuously 1, and retired_cnt increments by 1.
- **Illegal 0x00000000 accepted in IDLE:** → illegal_inst = 1, id_ready = 0, id_rf_valid_inst stays 0 for 10 cycles; rst clears it to IDLE.
